uart_cmd_link: RTL and testbench

//  Master-side command link: sends a 2-byte command frame (header + Hamming(7,4) code) to one

---
 rtl/uart_cmd_link_if.sv | 23 ++
 rtl/uart_cmd_link.sv | 169 ++++++++++++++++
 tb/tb_uart_cmd_link.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_link_if.sv
// Command-side bundle between the SPWM/sync controller (master) and uart_cmd_link (slave).
interface uart_cmd_link_if #(
  parameter int unsigned ADDR_W = 2
) ();
  logic              cmd_valid;
  logic              cmd_ready;
  logic [3:0]        cmd_code;
  logic [ADDR_W-1:0] cmd_addr;
  logic              cmd_bcast;
  logic              done;
  logic              fail;
  logic [1:0]        retries_used;

  modport master (
    output cmd_valid, cmd_code, cmd_addr, cmd_bcast,
    input  cmd_ready, done, fail, retries_used
  );

  modport slave (
    input  cmd_valid, cmd_code, cmd_addr, cmd_bcast,
    output cmd_ready, done, fail, retries_used
  );
endinterface

// File: rtl/uart_cmd_link.sv
// Sends a header + command byte over uart_tx, waits for an ACK from uart_rx with timeout,
// and retransmits up to MAX_RETRY times. Broadcast commands skip the ACK wait.
module uart_cmd_link #(
  parameter int unsigned ADDR_W      = 2,
  parameter int unsigned ACK_TIMEOUT = 4800,
  parameter int unsigned MAX_RETRY   = 3,
  parameter logic [7:0]  ACK_BYTE    = 8'h3C,
  parameter logic [7:0]  NACK_BYTE   = 8'hC3,
  parameter int unsigned USE_HAMMING = 1
) (
  input  logic       clk,
  input  logic       reset,
  uart_cmd_link_if.slave cmd,
  output logic       start_tx,
  output logic [7:0] data_to_tx,
  input  logic       tx_busy,
  input  logic [7:0] data_received,
  input  logic       rx_done,
  input  logic       parity_error
);

  localparam int unsigned TimerW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [3:0] {
    StIdle, StSendHdr, StWaitHdr, StSendCmd, StWaitCmd, StWaitAck, StRetry, StDone, StFail
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        code_q, code_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              bcast_q, bcast_d;
  logic [7:0]        data_q, data_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [1:0]        retry_q, retry_d;
  logic [1:0]        used_q, used_d;
  logic              busy_q;
  logic              tx_fall;
  logic              cmd_ready, done, fail;
  logic [7:0]        cmd_byte;

  function automatic logic [6:0] hamming74(input logic [3:0] d);
    logic p1, p2, p3;
    p1 = d[0] ^ d[1] ^ d[3];
    p2 = d[0] ^ d[2] ^ d[3];
    p3 = d[1] ^ d[2] ^ d[3];
    return {d[3], d[2], d[1], p3, d[0], p2, p1};
  endfunction

  function automatic logic [7:0] header(input logic [ADDR_W-1:0] a);
    return {4'hA, 4'(a)};
  endfunction

  assign cmd_byte = (USE_HAMMING != 0) ? {1'b1, hamming74(code_q)} : {4'h0, code_q};
  // Registered busy gives a clean falling-edge strobe marking the end of each byte.
  assign tx_fall  = busy_q & ~tx_busy;

  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    addr_d    = addr_q;
    bcast_d   = bcast_q;
    data_d    = data_q;
    timer_d   = timer_q;
    retry_d   = retry_q;
    used_d    = used_q;
    cmd_ready = 1'b0;
    start_tx  = 1'b0;
    done      = 1'b0;
    fail      = 1'b0;
    unique case (state_q)
      StIdle: begin
        cmd_ready = 1'b1;
        if (cmd.cmd_valid) begin
          code_d  = cmd.cmd_code;
          addr_d  = cmd.cmd_addr;
          bcast_d = cmd.cmd_bcast;
          retry_d = 2'd0;
          used_d  = 2'd0;
          data_d  = header(cmd.cmd_addr);
          state_d = StSendHdr;
        end
      end
      StSendHdr: begin
        start_tx = 1'b1;
        state_d  = StWaitHdr;
      end
      StWaitHdr: begin
        if (tx_fall) begin
          data_d  = cmd_byte;
          state_d = StSendCmd;
        end
      end
      StSendCmd: begin
        start_tx = 1'b1;
        state_d  = StWaitCmd;
      end
      StWaitCmd: begin
        if (tx_fall) begin
          timer_d = '0;
          state_d = bcast_q ? StDone : StWaitAck;
        end
      end
      StWaitAck: begin
        timer_d = timer_q + 1'b1;
        // A reply landing on the timeout cycle still counts.
        if (rx_done) begin
          state_d = (!parity_error && data_received == ACK_BYTE) ? StDone : StRetry;
        end else if (timer_q == TimerW'(ACK_TIMEOUT - 1)) begin
          state_d = StRetry;
        end
      end
      StRetry: begin
        if (retry_q < 2'(MAX_RETRY)) begin
          retry_d = retry_q + 2'd1;
          data_d  = header(addr_q);
          state_d = StSendHdr;
        end else begin
          state_d = StFail;
        end
      end
      StDone: begin
        done    = 1'b1;
        used_d  = retry_q;
        state_d = StIdle;
      end
      StFail: begin
        fail    = 1'b1;
        used_d  = retry_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      code_q  <= '0;
      addr_q  <= '0;
      bcast_q <= 1'b0;
      data_q  <= '0;
      timer_q <= '0;
      retry_q <= '0;
      used_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      addr_q  <= addr_d;
      bcast_q <= bcast_d;
      data_q  <= data_d;
      timer_q <= timer_d;
      retry_q <= retry_d;
      used_q  <= used_d;
      busy_q  <= tx_busy;
    end
  end

  assign data_to_tx       = data_q;
  assign cmd.cmd_ready    = cmd_ready;
  assign cmd.done         = done;
  assign cmd.fail         = fail;
  assign cmd.retries_used = used_q;

  // NACK needs no decode of its own: any non-ACK reply retries.
  logic unused_nack;
  assign unused_nack = ^NACK_BYTE;

endmodule

// File: tb/tb_uart_cmd_link.sv
// Directed bench for uart_cmd_link with a small uart_tx model and hand-computed frame bytes.
module tb_uart_cmd_link;
  localparam int unsigned AckTimeout = 40;
  localparam int unsigned TxLen      = 3;
  // Header-to-header period on timeout: 2 bytes x (send + TxLen busy + edge) + window + retry.
  localparam int unsigned Period     = AckTimeout + 2 * TxLen + 5;
  localparam int SelBytes = 0, SelFalls = 1, SelDone = 2, SelFail = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_tx;
  logic [7:0] data_to_tx;
  logic       tx_busy;
  logic [7:0] data_received;
  logic       rx_done;
  logic       parity_error;

  uart_cmd_link_if #(.ADDR_W(2)) cmd_if ();

  uart_cmd_link #(
    .ADDR_W     (2),
    .ACK_TIMEOUT(AckTimeout),
    .MAX_RETRY  (3),
    .ACK_BYTE   (8'h3C),
    .NACK_BYTE  (8'hC3),
    .USE_HAMMING(1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd          (cmd_if.slave),
    .start_tx     (start_tx),
    .data_to_tx   (data_to_tx),
    .tx_busy      (tx_busy),
    .data_received(data_received),
    .rx_done      (rx_done),
    .parity_error (parity_error)
  );

  always #5 clk = ~clk;

  int         cyc = 0;
  int         n_checks = 0;
  int         n_bad = 0;
  logic [7:0] tx_log[$];
  int         start_cyc[$];
  int         fall_cnt = 0;
  int         last_fall = 0;
  int         done_cnt = 0;
  int         done_cyc = 0;
  int         fail_cnt = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // uart_tx model: busy for TxLen cycles starting the cycle after start_tx.
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (start_tx === 1'b1) begin
        tx_log.push_back(data_to_tx);
        start_cyc.push_back(cyc);
        @(posedge clk);
        #1 tx_busy = 1'b1;
        repeat (TxLen) @(posedge clk);
        #1 tx_busy = 1'b0;
        fall_cnt++;
        last_fall = cyc;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (cmd_if.done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (cmd_if.fail === 1'b1) fail_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int get_cnt(input int sel);
    case (sel)
      SelBytes: return tx_log.size();
      SelFalls: return fall_cnt;
      SelDone:  return done_cnt;
      default:  return fail_cnt;
    endcase
  endfunction

  task automatic wait_cnt(input int sel, input int n, input string tag);
    int b = 0;
    while (get_cnt(sel) < n && b < 1000) begin
      @(posedge clk);
      #1;
      b++;
    end
    check(tag, 32'(get_cnt(sel) >= n), 32'd1);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear();
    tx_log.delete();
    start_cyc.delete();
    fall_cnt = 0;
    done_cnt = 0;
    fail_cnt = 0;
  endtask

  task automatic send_cmd(input logic [3:0] code, input logic [1:0] addr, input logic bcast);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_code  = code;
    cmd_if.cmd_addr  = addr;
    cmd_if.cmd_bcast = bcast;
    step(1);
    cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic perr, output int c);
    rx_done       = 1'b1;
    data_received = b;
    parity_error  = perr;
    c             = cyc;
    step(1);
    rx_done       = 1'b0;
    parity_error  = 1'b0;
  endtask

  int c;
  int target;

  initial begin
    reset = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_code  = 4'h0;
    cmd_if.cmd_addr  = 2'd0;
    cmd_if.cmd_bcast = 1'b0;
    rx_done = 1'b0;
    data_received = 8'h00;
    parity_error = 1'b0;
    step(3);
    check("rst_ready", cmd_if.cmd_ready, 1);
    check("rst_start", start_tx, 0);
    check("rst_data", data_to_tx, 0);
    check("rst_done_fail", {cmd_if.done, cmd_if.fail}, 0);
    check("rst_used", cmd_if.retries_used, 0);
    reset = 1'b1;
    step(2);

    // T1: unicast, ACK after frame
    clear();
    send_cmd(4'h6, 2'd2, 1'b0);
    check("t1_ready_low", cmd_if.cmd_ready, 0);
    wait_cnt(SelFalls, 2, "t1_frame");
    check("t1_hdr", tx_log[0], 8'hA2);
    check("t1_cmd", tx_log[1], 8'hB3);
    step(3);
    send_rx(8'h3C, 1'b0, c);
    wait_cnt(SelDone, 1, "t1_done");
    check("t1_done_lat", done_cyc, c + 1);
    check("t1_used", cmd_if.retries_used, 0);
    check("t1_ready_back", cmd_if.cmd_ready, 1);
    check("t1_done_1cyc", cmd_if.done, 0);

    // T2: broadcast, no ACK wait
    clear();
    send_cmd(4'hD, 2'd1, 1'b1);
    wait_cnt(SelDone, 1, "t2_done");
    check("t2_hdr", tx_log[0], 8'hA1);
    check("t2_cmd", tx_log[1], 8'hE6);
    check("t2_done_lat", done_cyc, last_fall + 1);
    check("t2_nbytes", tx_log.size(), 2);

    // T3: never acknowledged
    clear();
    send_cmd(4'h5, 2'd0, 1'b0);
    wait_cnt(SelFail, 1, "t3_fail");
    check("t3_nbytes", tx_log.size(), 8);
    for (int i = 1; i < 4; i++) check("t3_period", start_cyc[2*i] - start_cyc[2*i-2], Period);
    check("t3_last_hdr", tx_log[6], 8'hA0);
    check("t3_last_cmd", tx_log[7], 8'hAD);
    check("t3_used", cmd_if.retries_used, 3);
    check("t3_no_done", done_cnt, 0);
    check("t3_fail_1cyc", cmd_if.fail, 0);

    // T4: NACK forces an immediate resend
    clear();
    send_cmd(4'h6, 2'd3, 1'b0);
    wait_cnt(SelFalls, 2, "t4_frame1");
    step(3);
    send_rx(8'hC3, 1'b0, c);
    wait_cnt(SelBytes, 3, "t4_resend");
    check("t4_resend_lat", start_cyc[2], c + 2);
    check("t4_hdr2", tx_log[2], 8'hA3);
    wait_cnt(SelFalls, 4, "t4_frame2");
    step(3);
    send_rx(8'h3C, 1'b0, c);
    wait_cnt(SelDone, 1, "t4_done");
    check("t4_done_lat", done_cyc, c + 1);
    check("t4_used", cmd_if.retries_used, 1);

    // T5: parity-corrupted ACK retries; ACK on the timeout cycle is honoured
    clear();
    send_cmd(4'h9, 2'd1, 1'b0);
    wait_cnt(SelFalls, 2, "t5_frame1");
    check("t5_cmd", tx_log[1], 8'hCC);
    step(3);
    send_rx(8'h3C, 1'b1, c);
    wait_cnt(SelBytes, 3, "t5_resend");
    check("t5_resend_lat", start_cyc[2], c + 2);
    wait_cnt(SelFalls, 4, "t5_frame2");
    target = last_fall + int'(AckTimeout);
    while (cyc < target) step(1);
    send_rx(8'h3C, 1'b0, c);
    wait_cnt(SelDone, 1, "t5_done");
    check("t5_done_lat", done_cyc, c + 1);
    check("t5_used", cmd_if.retries_used, 1);
    step(AckTimeout + 10);
    check("t5_no_resend", tx_log.size(), 4);
    check("t5_no_fail", fail_cnt, 0);

    // T6: reset in the middle of the command byte
    clear();
    send_cmd(4'h6, 2'd2, 1'b0);
    wait_cnt(SelBytes, 2, "t6_cmd_start");
    step(1);
    #2 reset = 1'b0;
    #1;
    check("t6_ready", cmd_if.cmd_ready, 1);
    check("t6_start", start_tx, 0);
    check("t6_data", data_to_tx, 0);
    check("t6_used", cmd_if.retries_used, 0);
    step(1);
    reset = 1'b1;
    step(30);
    check("t6_no_done_fail", done_cnt + fail_cnt, 0);
    check("t6_ready_after", cmd_if.cmd_ready, 1);

    // Link still works after reset
    clear();
    send_cmd(4'h0, 2'd3, 1'b0);
    wait_cnt(SelFalls, 2, "t7_frame");
    check("t7_hdr", tx_log[0], 8'hA3);
    check("t7_cmd", tx_log[1], 8'h80);
    step(3);
    send_rx(8'h3C, 1'b0, c);
    wait_cnt(SelDone, 1, "t7_done");
    check("t7_used", cmd_if.retries_used, 0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end
endmodule
